pwm_breath_multi: RTL and testbench
===================================

PWM_BREATH_MULTI -- requirements
Module: pwm_breath_multi

Interface
REQ-001 Parameter PWM_PERIOD, default 500_000: clock cycles per PWM frame (10 ms at 50 MHz).
REQ-002 Parameter STEPS, default 100: brightness levels per half-ramp; PWM_PERIOD SHALL be an exact multiple of STEPS (STEP_CYC = PWM_PERIOD/STEPS).
REQ-003 Parameter FRAMES_PER_STEP, default 2: PWM frames spent at each brightness level.
REQ-004 Parameter CHANNELS, default 4: number of LED outputs, range 1..16.
REQ-005 Parameter PHASE_OFS, default 50: per-channel ramp phase offset in levels, range 0..2*STEPS-1.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 en  in  1  run enable; low = synchronous stop and clear.
REQ-009 mode  in  2  0 off, 1 steady full-on, 2 breathe, 3 blink (full-on/off per half-ramp).
REQ-010 led  out  CHANNELS  registered PWM outputs, active-high.
REQ-011 frame_tick  out  1  one-cycle pulse on the last cycle of every PWM frame.

Function
REQ-012 Frame counter fcnt SHALL count 0..PWM_PERIOD-1 and wrap; frame_tick=1 exactly when fcnt==PWM_PERIOD-1 and en=1.
REQ-013 Step counter SHALL count frames 0..FRAMES_PER_STEP-1, advancing on frame_tick.
REQ-014 Phase counter ph SHALL count 0..2*STEPS-1, advancing when frame_tick and step counter is at its terminal value, wrapping 2*STEPS-1 -> 0.
REQ-015 Channel i phase p_i = (ph + i*PHASE_OFS) mod 2*STEPS, computed without a divider (single conditional subtract suffices).
REQ-016 Breathe level L_i = p_i if p_i <= STEPS else 2*STEPS-p_i; sequence 0,1..STEPS..1, period 2*STEPS*FRAMES_PER_STEP frames.
REQ-017 Blink level L_i = STEPS if p_i < STEPS else 0; steady level = STEPS; off level = 0.
REQ-018 Per-channel compare cmp_i = L_i*STEP_CYC SHALL be latched only on frame_tick (and at start after en rises), so duty never changes mid-frame.
REQ-019 led[i] SHALL be 1 while fcnt < cmp_i, registered, i.e. one cycle after fcnt; cmp_i=0 gives 0 for whole frame, cmp_i=PWM_PERIOD gives 1 for whole frame.
REQ-020 mode is sampled only on frame_tick; changes take effect on the following frame without resetting ph.
REQ-021 en falling: next cycle fcnt, step counter, ph, all cmp_i SHALL be 0 and led all 0, frame_tick 0.
REQ-022 en rising: frame 0 starts with ph=0 and cmp_i computed from current mode and ph=0 on the first enabled cycle.
REQ-023 Counter widths SHALL be $clog2 of their ranges; multiply L_i*STEP_CYC SHALL be evaluated at width $clog2(PWM_PERIOD+1) without overflow.

Reset
REQ-024 On rst_n low: fcnt, step counter, ph, cmp_i = 0; led = 0; frame_tick = 0, asynchronously.
REQ-025 After rst_n release, behaviour SHALL be identical to an en rising edge when en=1.

Structure
REQ-026 Shared package pwm_pkg SHALL hold the mode encodings (MODE_OFF, MODE_ON, MODE_BREATHE, MODE_BLINK) and the level-to-compare helper function.
REQ-027 One sub-module pwm_chan (per-channel phase, level, compare register, output flop) SHALL be instantiated CHANNELS times in a generate loop; shared counters stay in the top.

Verification (PWM_PERIOD=20, STEPS=4, FRAMES_PER_STEP=1, CHANNELS=2, PHASE_OFS=4)
REQ-028 Reset mid-frame with led high -> led=00, frame_tick=0 immediately; after release frame_tick first at cycle 20.
REQ-029 mode=2, en=1 for 8 frames -> led[0] high-cycles per frame 0,5,10,15,20,15,10,5; led[1] 20,15,10,5,0,5,10,15.
REQ-030 mode=1 -> led=11 continuously, no low cycle at frame boundaries; mode=0 -> led=00 continuously.
REQ-031 mode=3 -> led[0] on 4 frames/off 4 frames, led[1] complementary.
REQ-032 mode 2->1 written at fcnt=7 -> current frame duty unchanged, next frame fully on; ph continues incrementing.
REQ-033 en dropped at fcnt=12 of frame 3 -> led=00 next cycle; en re-raised -> ramp restarts at level 0, duty 0 for channel 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared mode encodings and level-to-compare conversion for the multi-channel breathing PWM.
package pwm_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_BLINK   = 2'd3
   } mode_e;

   // Result never exceeds PWM_PERIOD, so callers narrow it to $clog2(PWM_PERIOD+1) bits.
   function automatic logic [31:0] level_to_cmp(input logic [31:0] level,
                                                input logic [31:0] step_cyc);
      return level * step_cyc;
   endfunction

endpackage

// File: rtl/pwm_chan.sv
// One LED channel: phase offset, brightness level, frame-latched compare value and output flop.
module pwm_chan
   import pwm_pkg::*;
#(
   parameter int PWM_PERIOD = 500_000,
   parameter int STEPS      = 100,
   parameter int PHASE_OFS  = 50,
   parameter int CH_IDX     = 0,
   parameter int FW         = $clog2(PWM_PERIOD),
   parameter int PW         = $clog2(2 * STEPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          start,
   input  logic          load,
   input  mode_e         mode,
   input  logic [PW-1:0] ph,
   input  logic [FW-1:0] fcnt,
   output logic          led
);

   localparam int STEP_CYC = PWM_PERIOD / STEPS;
   localparam int CW       = $clog2(PWM_PERIOD + 1);
   localparam int LW       = $clog2(STEPS + 1);
   localparam int PW1      = PW + 1;
   localparam int OFS      = (CH_IDX * PHASE_OFS) % (2 * STEPS);
   localparam logic [PW1-1:0] TWO_S   = PW1'(2 * STEPS);
   localparam logic [PW-1:0]  STEPS_P = PW'(STEPS);

   logic [PW1-1:0] sum;
   logic [PW-1:0]  p;
   logic [LW-1:0]  lvl;
   logic [CW-1:0]  cmp_q;
   logic [CW-1:0]  cmp_new;
   logic [CW-1:0]  cmp_eff;

   // Offset is pre-reduced, so one conditional subtract keeps the phase in range.
   assign sum = {1'b0, ph} + PW1'(OFS);
   assign p   = (sum >= TWO_S) ? PW'(sum - TWO_S) : PW'(sum);

   always_comb begin
      lvl = '0;
      case (mode)
         MODE_ON:      lvl = LW'(STEPS);
         MODE_BREATHE: lvl = (p <= STEPS_P) ? LW'(p) : LW'(TWO_S - {1'b0, p});
         MODE_BLINK:   lvl = (p < STEPS_P) ? LW'(STEPS) : '0;
         default:      lvl = '0;
      endcase
   end

   assign cmp_new = CW'(level_to_cmp(32'(lvl), 32'(STEP_CYC)));

   // On the first enabled cycle the register still holds 0, so use the fresh value directly.
   assign cmp_eff = start ? cmp_new : cmp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_q <= '0;
         led   <= 1'b0;
      end else if (!en) begin
         cmp_q <= '0;
         led   <= 1'b0;
      end else begin
         if (load) cmp_q <= cmp_new;
         led <= (CW'(fcnt) < cmp_eff);
      end
   end

endmodule

// File: rtl/pwm_breath_multi.sv
// Multi-channel breathing/blink LED PWM: shared frame/step/phase counters, per-channel compare.
module pwm_breath_multi
   import pwm_pkg::*;
#(
   parameter int PWM_PERIOD      = 500_000,
   parameter int STEPS           = 100,
   parameter int FRAMES_PER_STEP = 2,
   parameter int CHANNELS        = 4,
   parameter int PHASE_OFS       = 50
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   output logic [CHANNELS-1:0] led,
   output logic                frame_tick
);

   localparam int FW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int PW = $clog2(2 * STEPS);

   logic [FW-1:0] fcnt;
   logic [SW-1:0] scnt;
   logic [PW-1:0] ph;
   logic [PW-1:0] ph_next;
   logic          en_d;
   logic          step_tc;
   logic          start;
   logic          load;

   assign frame_tick = en && (fcnt == FW'(PWM_PERIOD - 1));
   assign step_tc    = (scnt == SW'(FRAMES_PER_STEP - 1));
   assign start      = en && !en_d;
   assign load       = start || frame_tick;

   // Channels latch their compare from the phase the next frame will run at.
   always_comb begin
      ph_next = ph;
      if (frame_tick && step_tc)
         ph_next = (ph == PW'(2 * STEPS - 1)) ? '0 : ph + PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= '0;
         scnt <= '0;
         ph   <= '0;
         en_d <= 1'b0;
      end else if (!en) begin
         fcnt <= '0;
         scnt <= '0;
         ph   <= '0;
         en_d <= 1'b0;
      end else begin
         en_d <= 1'b1;
         fcnt <= frame_tick ? '0 : fcnt + FW'(1);
         if (frame_tick) scnt <= step_tc ? '0 : scnt + SW'(1);
         ph <= ph_next;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      pwm_chan #(
         .PWM_PERIOD (PWM_PERIOD),
         .STEPS      (STEPS),
         .PHASE_OFS  (PHASE_OFS),
         .CH_IDX     (i),
         .FW         (FW),
         .PW         (PW)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .start (start),
         .load  (load),
         .mode  (mode_e'(mode)),
         .ph    (ph_next),
         .fcnt  (fcnt),
         .led   (led[i])
      );
   end

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Directed bench for pwm_breath_multi with a 20-cycle frame, 4 steps, two channels offset by half a ramp.
module tb_pwm_breath_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [1:0] led;
   logic       frame_tick;

   int vectors = 0;
   int errors  = 0;

   pwm_breath_multi #(
      .PWM_PERIOD      (20),
      .STEPS           (4),
      .FRAMES_PER_STEP (1),
      .CHANNELS        (2),
      .PHASE_OFS       (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .led        (led),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Called at the negedge inside the first cycle of a frame; ends at the same point of the next frame.
   task automatic measure_frame(output int h0, output int h1,
                                input int chg_at, input logic [1:0] chg_mode);
      h0 = 0;
      h1 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         h0 += int'(led[0]);
         h1 += int'(led[1]);
         if (i == chg_at) mode = chg_mode;
      end
   endtask

   task automatic restart(input logic [1:0] m);
      mode = m;
      en   = 1'b0;
      @(negedge clk);
      en   = 1'b1;
   endtask

   task automatic test_reset;
      int first;
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 2'd0;
      repeat (3) @(negedge clk);
      vectors++;
      if (led !== 2'b00) begin errors++; $display("FAIL reset_led got=%b exp=00", led); end
      vectors++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end

      // Mid-frame reset while LEDs are lit and frame_tick is high.
      en    = 1'b1;
      mode  = 2'd1;
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      while (!frame_tick) @(negedge clk);
      vectors++;
      if (led !== 2'b11) begin errors++; $display("FAIL prereset_led got=%b exp=11", led); end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (led !== 2'b00) begin errors++; $display("FAIL async_reset_led got=%b exp=00", led); end
      vectors++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL async_reset_tick got=%b exp=0", frame_tick); end

      @(negedge clk);
      rst_n = 1'b1;
      first = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (frame_tick) begin
            first = c + 1;
            break;
         end
      end
      vectors++;
      if (first != 20) begin errors++; $display("FAIL first_tick_cycle got=%0d exp=20", first); end
      @(negedge clk);
      vectors++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width got=%b exp=0", frame_tick); end
   endtask

   task automatic test_breathe;
      int exp0 [8] = '{0, 5, 10, 15, 20, 15, 10, 5};
      int exp1 [8] = '{20, 15, 10, 5, 0, 5, 10, 15};
      int h0, h1;
      rst_n = 1'b0;
      en    = 1'b1;
      mode  = 2'd2;
      @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < 8; f++) begin
         measure_frame(h0, h1, -1, 2'd2);
         vectors++;
         if (h0 != exp0[f]) begin errors++; $display("FAIL breathe_ch0 frame=%0d got=%0d exp=%0d", f, h0, exp0[f]); end
         vectors++;
         if (h1 != exp1[f]) begin errors++; $display("FAIL breathe_ch1 frame=%0d got=%0d exp=%0d", f, h1, exp1[f]); end
      end
   endtask

   task automatic test_steady;
      restart(2'd1);
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         vectors++;
         if (led !== 2'b11) begin errors++; $display("FAIL steady_on cycle=%0d got=%b exp=11", c, led); end
      end
      restart(2'd0);
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         vectors++;
         if (led !== 2'b00) begin errors++; $display("FAIL steady_off cycle=%0d got=%b exp=00", c, led); end
      end
   endtask

   task automatic test_blink;
      int h0, h1, e0, e1;
      restart(2'd3);
      for (int f = 0; f < 8; f++) begin
         measure_frame(h0, h1, -1, 2'd3);
         e0 = (f < 4) ? 20 : 0;
         e1 = (f < 4) ? 0 : 20;
         vectors++;
         if (h0 != e0) begin errors++; $display("FAIL blink_ch0 frame=%0d got=%0d exp=%0d", f, h0, e0); end
         vectors++;
         if (h1 != e1) begin errors++; $display("FAIL blink_ch1 frame=%0d got=%0d exp=%0d", f, h1, e1); end
      end
   endtask

   task automatic test_mode_switch;
      int h0, h1;
      restart(2'd2);
      repeat (3) measure_frame(h0, h1, -1, 2'd2);
      // Switch to steady at fcnt=7 of frame 3: that frame keeps its breathe duty.
      measure_frame(h0, h1, 6, 2'd1);
      vectors++;
      if (h0 != 15) begin errors++; $display("FAIL switch_cur_ch0 got=%0d exp=15", h0); end
      vectors++;
      if (h1 != 5) begin errors++; $display("FAIL switch_cur_ch1 got=%0d exp=5", h1); end
      measure_frame(h0, h1, 6, 2'd2);
      vectors++;
      if (h0 != 20 || h1 != 20) begin errors++; $display("FAIL switch_next got=%0d/%0d exp=20/20", h0, h1); end
      // Back in breathe, frame 5 shows the phase kept advancing.
      measure_frame(h0, h1, -1, 2'd2);
      vectors++;
      if (h0 != 15 || h1 != 5) begin errors++; $display("FAIL switch_phase got=%0d/%0d exp=15/5", h0, h1); end
   endtask

   task automatic test_en_drop;
      int h0, h1;
      restart(2'd2);
      repeat (3) measure_frame(h0, h1, -1, 2'd2);
      repeat (12) @(negedge clk);
      vectors++;
      if (led !== 2'b01) begin errors++; $display("FAIL pre_drop_led got=%b exp=01", led); end
      en = 1'b0;
      @(negedge clk);
      vectors++;
      if (led !== 2'b00) begin errors++; $display("FAIL drop_led got=%b exp=00", led); end
      vectors++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL drop_tick got=%b exp=0", frame_tick); end
      en = 1'b1;
      measure_frame(h0, h1, -1, 2'd2);
      vectors++;
      if (h0 != 0) begin errors++; $display("FAIL reenable_ch0 got=%0d exp=0", h0); end
      vectors++;
      if (h1 != 20) begin errors++; $display("FAIL reenable_ch1 got=%0d exp=20", h1); end
      measure_frame(h0, h1, -1, 2'd2);
      vectors++;
      if (h0 != 5 || h1 != 15) begin errors++; $display("FAIL reenable_next got=%0d/%0d exp=5/15", h0, h1); end
   endtask

   initial begin
      test_reset();
      test_breathe();
      test_steady();
      test_blink();
      test_mode_switch();
      test_en_drop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
